// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared definitions for the word-to-unit memory sequencing controllers.
//   - state encoding for the unit sequencing FSM
//   - unit_lsb(): bit offset of unit i inside a full bus word
//   - params_legal(): parameter legality check used at elaboration
package mem_ctrl_pkg;

  localparam logic [2:0] ENC_IDLE  = 3'd0;
  localparam logic [2:0] ENC_WR    = 3'd1;
  localparam logic [2:0] ENC_RD    = 3'd2;
  localparam logic [2:0] ENC_DRAIN = 3'd3;
  localparam logic [2:0] ENC_RESP  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = ENC_IDLE,
    ST_WR    = ENC_WR,
    ST_RD    = ENC_RD,
    ST_DRAIN = ENC_DRAIN,
    ST_RESP  = ENC_RESP
  } ctrl_state_t;

  // Units are little-endian: unit i occupies bits [i*unit_w +: unit_w].
  function automatic int unit_lsb(input int idx, input int unit_w);
    return idx * unit_w;
  endfunction

  // The unit count must be a power of two (so the unit index is a clean
  // address field), must divide the bus evenly, and must leave at least
  // one bit of word address.
  function automatic bit params_legal(input int bus_size,
                                      input int num_units,
                                      input int addr_width);
    return (num_units >= 2) &&
           ((num_units & (num_units - 1)) == 0) &&
           ((bus_size % num_units) == 0) &&
           ($clog2(num_units) < addr_width);
  endfunction

endpackage

// File: rtl/unit_assembler.sv
// unit_assembler
// Shift/capture register that builds a full bus word out of consecutive
// memory units. Each load shifts the word down by one unit and inserts the
// new unit at the top, so after NUM_UNITS loads the first unit loaded sits
// in the least significant position (little-endian reassembly).
// Ports:
//   clk, reset_L : clock, asynchronous active-low reset
//   load         : capture unit_in this cycle
//   unit_in      : unit-wide data from the memory
//   word         : registered assembled word
//   word_next    : value word takes on a load (lets a consumer grab the
//                  completed word in the same cycle the last unit arrives)
module unit_assembler #(
  parameter int BUS_SIZE   = 32,
  parameter int UNIT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  load,
  input  logic [UNIT_WIDTH-1:0] unit_in,
  output logic [BUS_SIZE-1:0]   word,
  output logic [BUS_SIZE-1:0]   word_next
);

  assign word_next = {unit_in, word[BUS_SIZE-1:UNIT_WIDTH]};

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      word <= '0;
    end else if (load) begin
      word <= word_next;
    end
  end

endmodule

// File: rtl/mem_word_ctrl.sv
// mem_word_ctrl
// Gives a full-width requester access to a single narrow synchronous
// memory port. Every request is split into NUM_MEM_UNITS unit accesses,
// unit 0 first, at memory address {word_addr, unit_idx}. Reads are
// reassembled into one word and returned with a one-cycle rsp_valid.
// Ports:
//   clk, reset_L            : clock, asynchronous active-low reset
//   req_valid/req_ready     : request handshake (ready only when idle)
//   req_write, req_addr,
//   req_wdata               : request direction, word address, write word
//   rsp_valid, rsp_rdata    : completion pulse and last assembled read word
//   mem_read, mem_write,
//   mem_address, mem_data_in: memory strobes, unit address and write unit
//   mem_data_out            : read unit, valid the cycle after mem_read
module mem_word_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int BUS_SIZE        = 32,
  parameter int ADDR_WIDTH      = 4,
  parameter int NUM_MEM_UNITS   = 4,
  parameter int MEM_UNIT_WIDTH  = BUS_SIZE / NUM_MEM_UNITS,
  parameter int UNIT_IDX_W      = $clog2(NUM_MEM_UNITS),
  parameter int WORD_ADDR_WIDTH = ADDR_WIDTH - UNIT_IDX_W
) (
  input  logic                       clk,
  input  logic                       reset_L,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [WORD_ADDR_WIDTH-1:0] req_addr,
  input  logic [BUS_SIZE-1:0]        req_wdata,
  output logic                       rsp_valid,
  output logic [BUS_SIZE-1:0]        rsp_rdata,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_WIDTH-1:0]      mem_address,
  output logic [MEM_UNIT_WIDTH-1:0]  mem_data_in,
  input  logic [MEM_UNIT_WIDTH-1:0]  mem_data_out
);

  if (!params_legal(BUS_SIZE, NUM_MEM_UNITS, ADDR_WIDTH)) begin : g_bad_params
    $error("mem_word_ctrl: illegal BUS_SIZE/NUM_MEM_UNITS/ADDR_WIDTH combination");
  end

  ctrl_state_t                state;
  logic [UNIT_IDX_W-1:0]      unit_idx;
  logic [WORD_ADDR_WIDTH-1:0] addr_q;
  logic [BUS_SIZE-1:0]        wdata_q;
  logic [BUS_SIZE-1:0]        rdata_q;
  logic                       ready_q;
  logic                       rd_capture;
  logic                       last_unit;
  logic                       accept;
  logic [BUS_SIZE-1:0]        asm_word;
  logic [BUS_SIZE-1:0]        asm_word_next;
  logic [MEM_UNIT_WIDTH-1:0]  wr_units [NUM_MEM_UNITS];

  // Split the latched write word into its units once, so the write data
  // path is a plain mux indexed by the unit counter.
  for (genvar i = 0; i < NUM_MEM_UNITS; i++) begin : g_wr_units
    assign wr_units[i] = wdata_q[unit_lsb(i, MEM_UNIT_WIDTH) +: MEM_UNIT_WIDTH];
  end

  assign last_unit = (unit_idx == UNIT_IDX_W'(NUM_MEM_UNITS - 1));
  assign accept    = req_valid && ready_q && (state == ST_IDLE);

  // Sequencing FSM. ready_q is registered so it only rises one edge after
  // reset releases and one edge after RESP; it drops on the accepting edge.
  // rd_capture delays the read strobe by one cycle to line up with the
  // registered memory output. The final read word is taken from the
  // assembler's next value while in DRAIN, so rsp_rdata is already complete
  // when RESP begins and is untouched by writes.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state      <= ST_IDLE;
      unit_idx   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      rd_capture <= 1'b0;
    end else begin
      rd_capture <= (state == ST_RD);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            unit_idx <= '0;
            ready_q  <= 1'b0;
            state    <= req_write ? ST_WR : ST_RD;
          end else begin
            ready_q  <= 1'b1;
          end
        end
        ST_WR: begin
          if (last_unit) begin
            unit_idx <= '0;
            state    <= ST_RESP;
          end else begin
            unit_idx <= unit_idx + UNIT_IDX_W'(1);
          end
        end
        ST_RD: begin
          if (last_unit) begin
            unit_idx <= '0;
            state    <= ST_DRAIN;
          end else begin
            unit_idx <= unit_idx + UNIT_IDX_W'(1);
          end
        end
        ST_DRAIN: begin
          rdata_q <= asm_word_next;
          state   <= ST_RESP;
        end
        ST_RESP: begin
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          unit_idx <= '0;
          ready_q  <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  unit_assembler #(
    .BUS_SIZE   (BUS_SIZE),
    .UNIT_WIDTH (MEM_UNIT_WIDTH)
  ) u_assembler (
    .clk       (clk),
    .reset_L   (reset_L),
    .load      (rd_capture),
    .unit_in   (mem_data_out),
    .word      (asm_word),
    .word_next (asm_word_next)
  );

  // Memory-side outputs depend only on registered state and counter, so a
  // reset drops them immediately and read/write are mutually exclusive.
  // Address and write data are forced to zero when no strobe is active.
  always_comb begin
    mem_write   = (state == ST_WR);
    mem_read    = (state == ST_RD);
    mem_address = '0;
    mem_data_in = '0;
    if (mem_write || mem_read) begin
      mem_address = {addr_q, unit_idx};
    end
    if (mem_write) begin
      mem_data_in = wr_units[unit_idx];
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = (state == ST_RESP);
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_word_ctrl.sv
// tb_mem_word_ctrl
// Drives mem_word_ctrl against a single-port synchronous memory model
// (registered read, write on the edge). Expected responses are pushed to a
// scoreboard queue when a request is driven and popped when rsp_valid is
// seen; per-cycle strobe/address/data timing is checked inside the
// stimulus task.
module tb_mem_word_ctrl;

  localparam int BUS_SIZE        = 32;
  localparam int ADDR_WIDTH      = 4;
  localparam int NUM_MEM_UNITS   = 4;
  localparam int MEM_UNIT_WIDTH  = 8;
  localparam int WORD_ADDR_WIDTH = 2;

  typedef struct packed {
    bit          is_read;
    logic [31:0] data;
  } rsp_t;

  logic                       clk = 1'b0;
  logic                       reset_L;
  logic                       req_valid;
  logic                       req_ready;
  logic                       req_write;
  logic [WORD_ADDR_WIDTH-1:0] req_addr;
  logic [BUS_SIZE-1:0]        req_wdata;
  logic                       rsp_valid;
  logic [BUS_SIZE-1:0]        rsp_rdata;
  logic                       mem_read;
  logic                       mem_write;
  logic [ADDR_WIDTH-1:0]      mem_address;
  logic [MEM_UNIT_WIDTH-1:0]  mem_data_in;
  logic [MEM_UNIT_WIDTH-1:0]  mem_data_out;

  logic [MEM_UNIT_WIDTH-1:0]  mem_arr [16];
  logic [31:0]                model_mem [4];
  logic [31:0]                model_rdata;
  rsp_t                       sb_q [$];
  int                         check_count = 0;
  int                         err_count = 0;
  int                         strobe_overlap = 0;

  mem_word_ctrl #(
    .BUS_SIZE      (BUS_SIZE),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .NUM_MEM_UNITS (NUM_MEM_UNITS)
  ) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  // Single-port memory: write on the edge, read data registered.
  always @(posedge clk) begin
    if (mem_write) mem_arr[mem_address] <= mem_data_in;
    if (mem_read)  mem_data_out <= mem_arr[mem_address];
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Response monitor: every rsp_valid must match the oldest scoreboard
  // entry; a write response must still show the last read word.
  always @(negedge clk) begin
    if (mem_read && mem_write) strobe_overlap++;
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        checkOutput("rspUnexpected", 64'd1, 64'd0);
      end else begin
        rsp_t exp_rsp;
        exp_rsp = sb_q.pop_front();
        checkOutput(exp_rsp.is_read ? "rspRead" : "rspHold", rsp_rdata, exp_rsp.data);
      end
    end
  end

  task automatic waitReady(output bit ok);
    int guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    ok = req_ready;
    if (!ok) checkOutput("readyTimeout", 64'd0, 64'd1);
  endtask

  // Called at a negedge. Drives one request, then checks every cycle of its
  // life up to the cycle where req_ready returns (leaves time there).
  task automatic applyStimulus(input bit is_write, input logic [1:0] waddr,
                               input logic [31:0] wdata, input bit hold_valid,
                               input bit toggle_valid);
    bit ok;
    rsp_t push;
    waitReady(ok);
    if (!ok) return;
    req_valid = 1'b1;
    req_write = is_write;
    req_addr  = waddr;
    req_wdata = wdata;
    if (is_write) begin
      model_mem[waddr] = wdata;
      push = '{is_read: 1'b0, data: model_rdata};
    end else begin
      model_rdata = model_mem[waddr];
      push = '{is_read: 1'b1, data: model_rdata};
    end
    sb_q.push_back(push);
    @(negedge clk);
    if (!hold_valid) req_valid = 1'b0;
    for (int i = 0; i < NUM_MEM_UNITS; i++) begin
      logic [13:0] exp_unit;
      logic [13:0] act_unit;
      exp_unit = {is_write, !is_write, waddr, 2'(i), is_write ? wdata[i*8 +: 8] : 8'h00};
      act_unit = {mem_write, mem_read, mem_address, is_write ? mem_data_in : 8'h00};
      checkOutput($sformatf("unit%0d", i), 64'(act_unit), 64'(exp_unit));
      if (toggle_valid) begin
        req_valid = ~req_valid;
        req_write = 1'($urandom);
        req_addr  = 2'($urandom);
      end
      @(negedge clk);
    end
    if (!is_write) begin
      checkOutput("drainCycle", {rsp_valid, mem_write, mem_read, req_ready}, 4'b0000);
      if (toggle_valid) req_valid = ~req_valid;
      @(negedge clk);
    end
    if (toggle_valid) req_valid = 1'b0;
    checkOutput("respCycle", {rsp_valid, mem_write, mem_read, req_ready}, 4'b1000);
    @(negedge clk);
    checkOutput("readyBack", {rsp_valid, mem_write, mem_read, req_ready}, 4'b0001);
  endtask

  initial begin
    bit ok;
    reset_L     = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    model_rdata = '0;
    for (int i = 0; i < 4; i++) model_mem[i] = '0;
    for (int i = 0; i < 16; i++) mem_arr[i] = '0;

    repeat (2) @(negedge clk);
    checkOutput("rstOutputs", {req_ready, rsp_valid, mem_read, mem_write,
                               mem_address, mem_data_in, rsp_rdata}, 64'd0);
    reset_L = 1'b1;
    checkOutput("rstReadyLow", 64'(req_ready), 64'd0);
    @(negedge clk);
    checkOutput("rstReadyHigh", 64'(req_ready), 64'd1);

    $display("[TB] write/read word 2");
    applyStimulus(1'b1, 2'd2, 32'hA1B2C3D4, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'd2, 32'h0,        1'b0, 1'b0);

    $display("[TB] back-to-back with req_valid held");
    applyStimulus(1'b1, 2'd3, 32'h11223344, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'd3, 32'h0,        1'b1, 1'b0);
    applyStimulus(1'b0, 2'd2, 32'h0,        1'b0, 1'b0);

    $display("[TB] req_valid toggling during a read");
    applyStimulus(1'b0, 2'd3, 32'h0, 1'b0, 1'b1);

    $display("[TB] reset in the middle of a write");
    applyStimulus(1'b1, 2'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
    waitReady(ok);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 2'd0;
    req_wdata = 32'h12345678;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("abortUnit0", {mem_write, mem_address, mem_data_in}, {1'b1, 4'd0, 8'h78});
    @(posedge clk);
    #2 reset_L = 1'b0;
    #1;
    checkOutput("abortOutputs", {req_ready, rsp_valid, mem_read, mem_write,
                                 mem_address, mem_data_in, rsp_rdata}, 64'd0);
    model_mem[0][7:0] = 8'h78;
    model_rdata = '0;
    @(negedge clk);
    reset_L = 1'b1;
    checkOutput("abortNoReady", 64'(req_ready), 64'd0);
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);

    $display("[TB] top word address");
    applyStimulus(1'b1, 2'd3, 32'hCAFEF00D, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'd3, 32'h0,        1'b0, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("strobeOverlap", 64'(strobe_overlap), 64'd0);
    checkOutput("sbEmpty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
